axi4_lite_iram_slave: RTL and testbench

- AXI4-Lite slave endpoint of the instruction-RAM frontend.
- Consumes the five channels driven by the frontend's AXI master and converts them into accesses on one internal single-port, byte-enabled instruction RAM.
- Serialises reads and writes with round-robin arbitration and returns OKAY/SLVERR responses typed from axi4_types.

---
 rtl/axi4_types.sv | 29 ++
 rtl/iram_sp_bytewe.sv | 32 +++
 rtl/axi4_lite_iram_slave.sv | 181 ++++++++++++++++++
 tb/tb_axi4_lite_iram_slave.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_types.sv
// axi4_types: AXI4 response encodings, the IRAM slave FSM state enum and
// the protection-field width shared by the instruction-RAM frontend.
package axi4_types;

    localparam int AXI_PROT_W = 3;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4_resp_el;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACC,
        WR_MEM,
        WR_RESP,
        RD_ACC,
        RD_MEM,
        RD_DATA
    } iram_slv_state_e;

    // Map an error flag onto the AXI response code.
    function automatic axi4_resp_el resp_of(input logic err);
        return err ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/iram_sp_bytewe.sv
// iram_sp_bytewe: single-port instruction RAM with per-byte write enables and
// a registered read port. Kept behavioural so it can be swapped for a macro.
module iram_sp_bytewe #(
    parameter  int DATA_SIZE = 32,
    parameter  int MEM_DEPTH = 4096,
    localparam int STRB_SIZE = DATA_SIZE / 8,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [STRB_SIZE-1:0] we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

    // Byte-lane write and registered read on the same enabled cycle.
    // NOTE: the array and its read register have no reset; RAM macros cannot be cleared and contents must survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < STRB_SIZE; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi4_lite_iram_slave.sv
// axi4_lite_iram_slave: AXI4-Lite slave that serialises reads and writes onto
// one single-port byte-enabled instruction RAM with round-robin arbitration.
// Build option: define IRAM_OOR_SLVERR_EN to answer out-of-range word indices
// with SLVERR (write suppressed, rdata 0); otherwise the index wraps.
module axi4_lite_iram_slave
    import axi4_types::*;
#(
    parameter  int ADDR_SIZE = 24,
    parameter  int DATA_SIZE = 32,
    parameter  int MEM_DEPTH = 4096,
    localparam int STRB_SIZE = DATA_SIZE / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_SIZE-1:0]  awaddr,
    input  logic [AXI_PROT_W-1:0] awprot,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_SIZE-1:0]  wdata,
    input  logic [STRB_SIZE-1:0]  wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output axi4_resp_el           bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_SIZE-1:0]  araddr,
    input  logic [AXI_PROT_W-1:0] arprot,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_SIZE-1:0]  rdata,
    output axi4_resp_el           rresp
);

    localparam int OFF    = $clog2(STRB_SIZE);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int IDX_W  = ADDR_SIZE - OFF;

    iram_slv_state_e      state;
    logic                 prio_wr;
    logic                 aw_held;
    logic                 w_held;
    logic [MEM_AW-1:0]    addr_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [STRB_SIZE-1:0] wstrb_q;
    logic                 oor;
    logic                 ram_en;
    logic [STRB_SIZE-1:0] ram_we;
    logic [DATA_SIZE-1:0] ram_rdata;
    logic                 unused_ok;

`ifdef IRAM_OOR_SLVERR_EN
    logic oor_q;

    // True when the word index lies beyond the RAM.
    function automatic logic index_oor(input logic [ADDR_SIZE-1:0] a);
        return {1'b0, a[ADDR_SIZE-1:OFF]} >= (IDX_W + 1)'(MEM_DEPTH);
    endfunction

    assign oor = oor_q;
`else
    assign oor = 1'b0;
`endif

    // Protection bits and address bits outside the RAM index carry no meaning here.
    assign unused_ok = ^{awprot, arprot, awaddr, araddr};

    // Transaction FSM: arbitration, channel handshakes and all registered outputs.
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= IDLE;
            prio_wr <= 1'b1;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            arready <= 1'b0;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            bresp   <= OKAY;
            rresp   <= OKAY;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
`ifdef IRAM_OOR_SLVERR_EN
            oor_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if ((awvalid || wvalid) && (prio_wr || !arvalid)) begin
                        state   <= WR_ACC;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end else if (arvalid) begin
                        state   <= RD_ACC;
                        arready <= 1'b1;
                    end
                end
                WR_ACC: begin
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        aw_held <= 1'b1;
                        addr_q  <= awaddr[OFF +: MEM_AW];
`ifdef IRAM_OOR_SLVERR_EN
                        oor_q   <= index_oor(awaddr);
`endif
                    end
                    if (wvalid && wready) begin
                        wready  <= 1'b0;
                        w_held  <= 1'b1;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    if (aw_held && w_held) begin
                        state <= WR_MEM;
                    end
                end
                WR_MEM: begin
                    state  <= WR_RESP;
                    bvalid <= 1'b1;
                    bresp  <= resp_of(oor);
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        prio_wr <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RD_ACC: begin
                    if (arvalid) begin
                        arready <= 1'b0;
                        addr_q  <= araddr[OFF +: MEM_AW];
`ifdef IRAM_OOR_SLVERR_EN
                        oor_q   <= index_oor(araddr);
`endif
                        state   <= RD_MEM;
                    end
                end
                RD_MEM: begin
                    state  <= RD_DATA;
                    rvalid <= 1'b1;
                    rresp  <= resp_of(oor);
                end
                RD_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        prio_wr <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM is touched only in the two memory states; out-of-range writes are masked.
    assign ram_en = (state == WR_MEM) || (state == RD_MEM);
    assign ram_we = (state == WR_MEM && !oor) ? wstrb_q : '0;

    // Read data comes straight from the RAM output register, zeroed outside a valid in-range beat.
    assign rdata = (rvalid && !oor) ? ram_rdata : '0;

    iram_sp_bytewe #(
        .DATA_SIZE (DATA_SIZE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (ACLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi4_lite_iram_slave.sv
// Testbench for axi4_lite_iram_slave: directed scenarios plus a randomized
// phase, checked by a queue-based scoreboard against a word-array model.
module tb_axi4_lite_iram_slave;
    import axi4_types::*;

    localparam int ADDR_SIZE = 24;
    localparam int DATA_SIZE = 32;
    localparam int STRB_SIZE = 4;
    localparam int MEM_DEPTH = 4096;
    localparam int TMO       = 64;
`ifdef IRAM_OOR_SLVERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    logic                 ACLK = 1'b0;
    logic                 ARESET = 1'b1;
    logic                 awvalid, awready, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rvalid, rready;
    logic [ADDR_SIZE-1:0] awaddr, araddr;
    logic [2:0]           awprot, arprot;
    logic [DATA_SIZE-1:0] wdata, rdata;
    logic [STRB_SIZE-1:0] wstrb;
    axi4_resp_el          bresp, rresp;

    always #5 ACLK = ~ACLK;

    axi4_lite_iram_slave #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awprot (awprot),
        .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb),
        .bvalid (bvalid), .bready (bready), .bresp (bresp),
        .arvalid (arvalid), .arready (arready), .araddr (araddr), .arprot (arprot),
        .rvalid (rvalid), .rready (rready), .rdata (rdata), .rresp (rresp)
    );

    typedef struct packed {
        logic [31:0] data;
        axi4_resp_el resp;
    } rexp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_mem [int];
    axi4_resp_el exp_b [$];
    rexp_t       exp_r [$];
    logic [7:0]  done_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word array indexed by byte address / 4.
    function automatic bit is_oor(input logic [23:0] a);
        return OOR_EN && (int'(a >> 2) >= MEM_DEPTH);
    endfunction

    function automatic int eff_idx(input logic [23:0] a);
        return int'(a >> 2) % MEM_DEPTH;
    endfunction

    function automatic axi4_resp_el model_write(input logic [23:0] a, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] w;
        if (is_oor(a)) return SLVERR;
        w = model_mem.exists(eff_idx(a)) ? model_mem[eff_idx(a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        model_mem[eff_idx(a)] = w;
        return OKAY;
    endfunction

    function automatic rexp_t model_read(input logic [23:0] a);
        rexp_t e;
        if (is_oor(a)) begin
            e.data = 32'h0;
            e.resp = SLVERR;
        end else begin
            e.data = model_mem[eff_idx(a)];
            e.resp = OKAY;
        end
        return e;
    endfunction

    function automatic bit known(input logic [23:0] a);
        return is_oor(a) || model_mem.exists(eff_idx(a));
    endfunction

    // Monitor: compares every presented response beat with the queue head.
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (bvalid) begin
                    check("b_expected", exp_b.size() > 0, 1);
                    if (exp_b.size() > 0) begin
                        check("bresp", bresp, exp_b[0]);
                        if (bready) begin
                            void'(exp_b.pop_front());
                            done_log.push_back("W");
                        end
                    end
                end
                if (rvalid) begin
                    check("r_expected", exp_r.size() > 0, 1);
                    if (exp_r.size() > 0) begin
                        check("rdata", rdata, exp_r[0].data);
                        check("rresp", rresp, exp_r[0].resp);
                        if (rready) begin
                            void'(exp_r.pop_front());
                            done_log.push_back("R");
                        end
                    end
                end
            end
        end
    end

    // Write transaction; entered and left just after a rising edge.
    // b_dly < 0 raises bready before bvalid appears.
    task automatic do_write(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit chk_lat);
        time aw_hs, w_hs, last_hs;
        int  k;
        exp_b.push_back(model_write(addr, data, strb));
        if (b_dly < 0) bready = 1'b1;
        fork
            begin
                int n = 0;
                repeat (aw_dly) begin @(posedge ACLK); #1; end
                awvalid = 1'b1;
                awaddr  = addr;
                do begin @(negedge ACLK); n++; end while (!awready && n < TMO);
                check("aw_handshake", awready, 1);
                @(posedge ACLK);
                aw_hs = $time;
                #1 awvalid = 1'b0;
                awaddr = 24'($urandom);
                @(negedge ACLK);
                check("awready_drop", awready, 0);
            end
            begin
                int n = 0;
                repeat (w_dly) begin @(posedge ACLK); #1; end
                wvalid = 1'b1;
                wdata  = data;
                wstrb  = strb;
                do begin @(negedge ACLK); n++; end while (!wready && n < TMO);
                check("w_handshake", wready, 1);
                @(posedge ACLK);
                w_hs = $time;
                #1 wvalid = 1'b0;
                wdata = $urandom;
                wstrb = 4'($urandom);
                @(negedge ACLK);
                check("wready_drop", wready, 0);
            end
        join
        last_hs = (aw_hs > w_hs) ? aw_hs : w_hs;
        k = 0;
        do begin @(negedge ACLK); k++; end while (!bvalid && k < TMO);
        check("bvalid_seen", bvalid, 1);
        if (chk_lat) check("b_latency", $time - last_hs, 64'd25);
        if (b_dly >= 0) begin
            @(posedge ACLK); #1;
            repeat (b_dly) begin @(posedge ACLK); #1; end
            bready = 1'b1;
            @(negedge ACLK);
        end
        check("b_hold", bvalid, 1);
        @(posedge ACLK);
        #1 bready = 1'b0;
    endtask

    // Read transaction; r_dly < 0 raises rready before rvalid appears.
    task automatic do_read(input logic [23:0] addr, input int ar_dly, input int r_dly, input bit chk_lat);
        time t_set, hs;
        int  k;
        exp_r.push_back(model_read(addr));
        if (r_dly < 0) rready = 1'b1;
        repeat (ar_dly) begin @(posedge ACLK); #1; end
        arvalid = 1'b1;
        araddr  = addr;
        t_set   = $time;
        k = 0;
        do begin @(negedge ACLK); k++; end while (!arready && k < TMO);
        check("ar_handshake", arready, 1);
        if (chk_lat) check("ar_latency", $time - t_set, 64'd14);
        @(posedge ACLK);
        hs = $time;
        #1 arvalid = 1'b0;
        araddr = 24'($urandom);
        k = 0;
        do begin @(negedge ACLK); k++; end while (!rvalid && k < TMO);
        check("rvalid_seen", rvalid, 1);
        if (chk_lat) check("r_latency", $time - hs, 64'd15);
        if (r_dly >= 0) begin
            @(posedge ACLK); #1;
            repeat (r_dly) begin @(posedge ACLK); #1; end
            rready = 1'b1;
            @(negedge ACLK);
        end
        check("r_hold", rvalid, 1);
        @(posedge ACLK);
        #1 rready = 1'b0;
    endtask

    function automatic logic [23:0] rand_addr();
        int r;
        int idx;
        r = int'($urandom_range(0, 9));
        if (r < 6)      idx = int'($urandom_range(0, 7));
        else if (r < 8) idx = int'($urandom_range(4088, 4095));
        else            idx = MEM_DEPTH + int'($urandom_range(0, 7));
        return 24'(idx * 4 + int'($urandom_range(0, 3)));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: still running at %0t, limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int k;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bresp", bresp, OKAY);
        check("rst_rresp", rresp, OKAY);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // Single full write and read-back
        do_write(24'h000010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1);
        do_read(24'h000010, 0, 0, 1);

        // Partial strobe, misaligned read-back with rready held early
        do_write(24'h000010, 32'h11223344, 4'h5, 0, 0, -1, 1);
        do_read(24'h000011, 0, -1, 1);

        // W three cycles ahead of AW, bready low for four cycles
        do_write(24'h000020, 32'hCAFEF00D, 4'hF, 3, 0, 4, 1);
        do_read(24'h000020, 1, 2, 1);

        // Contention: all requests valid out of reset
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        done_log.delete();
        fork
            begin #2 ARESET = 1'b0; end
            begin
                do_write(24'h000030, 32'h0BADF00D, 4'hF, 0, 0, 0, 0);
                do_write(24'h000034, 32'h5EED1234, 4'hF, 0, 0, 0, 0);
            end
            begin
                do_read(24'h000010, 0, 0, 0);
                do_read(24'h000020, 0, 0, 0);
            end
        join
        check("order_len", done_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < done_log.size()) check("order", done_log[i], (i % 2 == 0) ? "W" : "R");
        end

        // Out-of-range index 0x1000 (wraps onto word 0 without the option)
        do_write(24'h000000, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 1);
        do_write(24'h004000, 32'h12345678, 4'hF, 0, 0, 0, 1);
        do_read(24'h004000, 0, 0, 1);
        do_read(24'h000000, 0, 0, 1);

        // Asynchronous reset while a read beat is waiting for rready
        exp_r.push_back(model_read(24'h000010));
        arvalid = 1'b1;
        araddr  = 24'h000010;
        k = 0;
        do begin @(negedge ACLK); k++; end while (!arready && k < TMO);
        check("rst_ar_handshake", arready, 1);
        @(posedge ACLK);
        #1 arvalid = 1'b0;
        k = 0;
        do begin @(negedge ACLK); k++; end while (!rvalid && k < TMO);
        check("rst_rvalid_seen", rvalid, 1);
        @(posedge ACLK);
        #3 ARESET = 1'b1;
        #1;
        check("async_rst_rvalid", rvalid, 0);
        check("async_rst_rdata", rdata, 0);
        void'(exp_r.pop_front());
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(posedge ACLK); #1;
        do_read(24'h000010, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [23:0] a;
            a = rand_addr();
            if ($urandom_range(0, 1) == 1 || !known(a)) begin
                do_write(a, $urandom, known(a) ? 4'($urandom_range(1, 15)) : 4'hF,
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)) - 1, 1);
            end else begin
                do_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)) - 1, 1);
            end
        end

        repeat (2) @(posedge ACLK);
        check("b_queue_drained", exp_b.size(), 0);
        check("r_queue_drained", exp_r.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
